// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package ssd_pkg;

    localparam logic [7:0] SEG_OFF       = 8'hFF;
    localparam int         DIGITS        = 4;
    localparam int         SCAN_DIV_DEF  = 100000;
    localparam int         BLANK_CYC_DEF = 1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } ssd_state_e;

endpackage

// File: rtl/ssd_frame_buf.sv
// Pending/shadow frame registers for the scan controller.
// Optional brightness capture is enabled with SSD_SCAN_DIM_EN.
module ssd_frame_buf
    import ssd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [31:0] upd_data,
`ifdef SSD_SCAN_DIM_EN
    input  logic [3:0]  bright,
    output logic [3:0]  bright_shadow,
`endif
    input  logic        apply_req,
    output logic [31:0] shadow
);

    // Handshake: a word transfers on a rising edge where upd_valid && upd_ready.
    // upd_ready is simply "pending empty"; a held offer waits until the next
    // apply empties pending, so nothing is ever dropped.
    logic        pending_full;
    logic [31:0] pending;
    logic        capture;
`ifdef SSD_SCAN_DIM_EN
    logic [3:0]  pending_bright;
`endif

    assign upd_ready = ~pending_full;
    assign capture   = upd_valid & ~pending_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_full   <= 1'b0;
            pending        <= '0;
            shadow         <= {DIGITS{SEG_OFF}};
`ifdef SSD_SCAN_DIM_EN
            pending_bright <= 4'h0;
            bright_shadow  <= 4'hF;
`endif
        end else if (capture) begin
            pending        <= upd_data;
            pending_full   <= 1'b1;
`ifdef SSD_SCAN_DIM_EN
            pending_bright <= bright;
`endif
        end else if (apply_req && pending_full) begin
            // Capture and apply never coincide: capture needs pending empty.
            shadow         <= pending;
            pending_full   <= 1'b0;
`ifdef SSD_SCAN_DIM_EN
            bright_shadow  <= pending_bright;
`endif
        end
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit seven-segment refresh scheduler with per-slot blanking.
// Define SSD_SCAN_DIM_EN to add the PWM brightness input `bright`.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int SCAN_DIV  = SCAN_DIV_DEF,
    parameter int BLANK_CYC = BLANK_CYC_DEF,
    parameter int CNT_W     = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [31:0] upd_data,
`ifdef SSD_SCAN_DIM_EN
    input  logic [3:0]  bright,
`endif
    output logic [1:0]  ssd_ctl,
    output logic [7:0]  display0,
    output logic [7:0]  display1,
    output logic [7:0]  display2,
    output logic [7:0]  display3,
    output logic        frame_done,
    output ssd_state_e  state_dbg
);

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    ssd_state_e       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       ctl, ctl_n;
    logic             boundary;
    logic             apply_req;
    logic             seg_on;
    logic [31:0]      shadow;
    logic [7:0]       disp_q [DIGITS];
    logic [7:0]       disp_n [DIGITS];
`ifdef SSD_SCAN_DIM_EN
    logic [3:0]       bright_sh;
    logic [3:0]       pwm, pwm_n;
`endif

    // Idle applies a waiting frame at once; running applies only at frame wrap.
    assign apply_req = boundary | (state == IDLE);

    ssd_frame_buf u_frame_buf (
        .clk           (clk),
        .rst_n         (rst_n),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready),
        .upd_data      (upd_data),
`ifdef SSD_SCAN_DIM_EN
        .bright        (bright),
        .bright_shadow (bright_sh),
`endif
        .apply_req     (apply_req),
        .shadow        (shadow)
    );

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        ctl_n    = ctl;
        boundary = 1'b0;
        if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
            ctl_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = BLANK;
                    cnt_n   = '0;
                    ctl_n   = '0;
                end
                BLANK: begin
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt == BLANK_LAST) state_n = SHOW;
                end
                SHOW: begin
                    if (cnt == SLOT_LAST) begin
                        cnt_n    = '0;
                        ctl_n    = ctl + 2'd1;
                        state_n  = BLANK;
                        boundary = (ctl == 2'd3);
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    ctl_n   = '0;
                end
            endcase
        end
    end

    // Display registers are loaded from the next state so they line up with it.
    always_comb begin
        seg_on = 1'b1;
`ifdef SSD_SCAN_DIM_EN
        pwm_n  = (state_n == SHOW && state == SHOW) ? pwm + 4'd1 : 4'd0;
        seg_on = (bright_sh == 4'hF) || (pwm_n < bright_sh);
`endif
        for (int i = 0; i < DIGITS; i++) begin
            disp_n[i] = SEG_OFF;
            if (state_n == SHOW && ctl_n == 2'(i) && seg_on)
                disp_n[i] = shadow[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ctl        <= '0;
            frame_done <= 1'b0;
            for (int i = 0; i < DIGITS; i++) disp_q[i] <= SEG_OFF;
`ifdef SSD_SCAN_DIM_EN
            pwm        <= 4'd0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ctl        <= ctl_n;
            frame_done <= boundary;
            for (int i = 0; i < DIGITS; i++) disp_q[i] <= disp_n[i];
`ifdef SSD_SCAN_DIM_EN
            pwm        <= pwm_n;
`endif
        end
    end

    assign ssd_ctl   = ctl;
    assign state_dbg = state;
    assign display0  = disp_q[0];
    assign display1  = disp_q[1];
    assign display2  = disp_q[2];
    assign display3  = disp_q[3];

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl (SCAN_DIV=8, BLANK_CYC=2).
module tb_ssd_scan_ctrl;
    import ssd_pkg::*;

    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_data = '0;
    logic        upd_ready;
    logic [1:0]  ssd_ctl;
    logic [7:0]  display0, display1, display2, display3;
    logic        frame_done;
    ssd_state_e  state_dbg;
    logic [7:0]  disp [4];
`ifdef SSD_SCAN_DIM_EN
    logic [3:0]  bright = 4'hF;
    logic [3:0]  m_pb, m_sb;
`endif

    // Model: position within the frame since the scan was enabled.
    bit          m_run;
    int          m_t;
    bit          m_full;
    bit          m_xfer;
    logic [31:0] m_pend, m_shadow;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          chk_on = 1'b0;

    ssd_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_data   (upd_data),
`ifdef SSD_SCAN_DIM_EN
        .bright     (bright),
`endif
        .ssd_ctl    (ssd_ctl),
        .display0   (display0),
        .display1   (display1),
        .display2   (display2),
        .display3   (display3),
        .frame_done (frame_done),
        .state_dbg  (state_dbg)
    );

    assign disp[0] = display0;
    assign disp[1] = display1;
    assign disp[2] = display2;
    assign disp[3] = display3;

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_t = 0; m_full = 0; m_xfer = 0;
        m_pend = '0; m_shadow = '1;
`ifdef SSD_SCAN_DIM_EN
        m_pb = 4'h0; m_sb = 4'hF;
`endif
    endtask

    function automatic logic [7:0] exp_disp(input int i);
        int pos;
        bit on;
        pos = m_t % SD;
        if (!m_run || pos < BC || (m_t / SD) != i) return 8'hFF;
        on = 1'b1;
`ifdef SSD_SCAN_DIM_EN
        on = (m_sb == 4'hF) || (((pos - BC) % 16) < int'(m_sb));
`endif
        return on ? m_shadow[8*i +: 8] : 8'hFF;
    endfunction

    always @(posedge clk) begin : model_step
        bit was_idle;
        bit bnd;
        if (rst_n) begin
            was_idle = !m_run;
            bnd      = 1'b0;
            m_xfer   = upd_valid && !m_full;
            if (!en) begin
                m_run = 0; m_t = 0;
            end else if (!m_run) begin
                m_run = 1; m_t = 0;
            end else begin
                m_t = (m_t + 1) % FRAME;
                bnd = (m_t == 0);
            end
            if (m_full && (was_idle || bnd)) begin
                m_shadow = m_pend;
                m_full   = 0;
`ifdef SSD_SCAN_DIM_EN
                m_sb     = m_pb;
`endif
            end
            if (m_xfer) begin
                m_pend = upd_data;
                m_full = 1;
`ifdef SSD_SCAN_DIM_EN
                m_pb   = bright;
`endif
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("ssd_ctl", 32'(ssd_ctl), m_run ? 32'(m_t / SD) : 32'd0);
            for (int i = 0; i < 4; i++) chk($sformatf("display%0d", i), 32'(disp[i]), 32'(exp_disp(i)));
            chk("frame_done", 32'(frame_done), 32'(m_run && m_t == 0 && !m_first_slot()));
            chk("upd_ready", 32'(upd_ready), 32'(!m_full));
            chk("state", 32'(state_dbg),
                !m_run ? 32'(IDLE) : ((m_t % SD) < BC ? 32'(BLANK) : 32'(SHOW)));
        end
    end

    // Frame boundary is distinguishable from the enable start by the wrap flag.
    bit m_wrapped;
    always @(posedge clk) begin
        if (!rst_n || !en) m_wrapped <= 1'b0;
        else if (m_run && m_t == FRAME - 1) m_wrapped <= 1'b1;
        else m_wrapped <= 1'b0;
    end
    function automatic bit m_first_slot();
        return !m_wrapped;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (upd_valid && m_xfer) upd_valid = 1'b0;
    endtask

    task automatic wait_fd(input string nm, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_done && n < budget);
        if (!frame_done) begin
            n_checks++; n_fail++;
            $display("FAIL %s: frame_done not seen within %0d cycles", nm, budget);
        end
    endtask

    task automatic wait_t(input string nm, input int target, input int budget);
        int n;
        n = 0;
        while (!(m_run && m_t == target) && n < budget) begin
            tick();
            n++;
        end
        if (!(m_run && m_t == target)) begin
            n_checks++; n_fail++;
            $display("FAIL %s: frame position %0d not reached within %0d cycles", nm, target, budget);
        end
    endtask

    initial begin
        logic [31:0] w;
        int fd_cnt;
        bit saw_stale;
        int on_cnt;
        model_reset();
        m_wrapped = 0;
        repeat (3) @(negedge clk);
        chk("rst_ssd_ctl", 32'(ssd_ctl), 32'd0);
        chk("rst_display0", 32'(display0), 32'hFF);
        chk("rst_display3", 32'(display3), 32'hFF);
        chk("rst_upd_ready", 32'(upd_ready), 32'd1);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        #1 rst_n = 1'b1;
        chk_on = 1'b1;

        // 1: free-running scan with blank frames
        en = 1'b1;
        fd_cnt = 0;
        tick();
        for (int n = 0; n < 100; n++) begin
            if (n == 8)  chk("t1_ctl_slot1", 32'(ssd_ctl), 32'd1);
            if (n == 24) chk("t1_ctl_slot3", 32'(ssd_ctl), 32'd3);
            if (n == 33) chk("t1_ctl_wrap", 32'(ssd_ctl), 32'd0);
            if (frame_done) begin
                chk("t1_fd_period", 32'(n % FRAME), 32'd0);
                fd_cnt++;
            end
            tick();
        end
        chk("t1_fd_count", 32'(fd_cnt), 32'd3);

        // 2: a frame offered mid-frame appears from the next boundary
        w = 32'hC0F9A4B0;
        upd_valid = 1'b1; upd_data = w;
        tick();
        chk("t2_ready_low", 32'(upd_ready), 32'd0);
        wait_fd("t2_wait_fd", 40);
        chk("t2_ready_high", 32'(upd_ready), 32'd1);
        for (int p = 0; p < FRAME; p++) begin
            chk($sformatf("t2_digit%0d_pos%0d", p / SD, p % SD), 32'(disp[p / SD]),
                (p % SD) < BC ? 32'hFF : 32'(w[8*(p / SD) +: 8]));
            tick();
        end

        // 3: second offer stalls while pending is full
        repeat (3) tick();
        upd_valid = 1'b1; upd_data = 32'h9282F880;
        tick();
        upd_valid = 1'b1; upd_data = 32'h99908883;
        tick();
        chk("t3_stall_ready", 32'(upd_ready), 32'd0);
        wait_fd("t3_wait_fd1", 40);
        tick(); tick();
        chk("t3_first_word", 32'(display0), 32'h80);
        wait_fd("t3_wait_fd2", 40);
        tick(); tick();
        chk("t3_second_word", 32'(display0), 32'h83);

        // 4: transfer exactly on the boundary with pending empty
        wait_t("t4_pos", FRAME - 1, 40);
        upd_valid = 1'b1; upd_data = 32'h8E86A1C6;
        tick();
        chk("t4_fd", 32'(frame_done), 32'd1);
        tick(); tick();
        chk("t4_shadow_kept", 32'(display0), 32'h83);
        wait_fd("t4_wait_fd", 40);
        tick(); tick();
        chk("t4_new_word", 32'(display0), 32'hC6);

        // 5: drop en during digit 2 SHOW with a frame pending
        wait_t("t5_pos", 2 * SD + 3, 40);
        upd_valid = 1'b1; upd_data = 32'hF89299A4;
        tick();
        en = 1'b0;
        tick();
        chk("t5_idle_state", 32'(state_dbg), 32'(IDLE));
        chk("t5_idle_ctl", 32'(ssd_ctl), 32'd0);
        chk("t5_idle_disp2", 32'(display2), 32'hFF);
        tick();
        chk("t5_idle_apply", 32'(upd_ready), 32'd1);
        en = 1'b1;
        tick();
        chk("t5_restart_ctl", 32'(ssd_ctl), 32'd0);
        chk("t5_restart_blank", 32'(display0), 32'hFF);
        tick(); tick();
        chk("t5_restart_show", 32'(display0), 32'hA4);

        // 6: asynchronous reset mid-SHOW discards the pending frame
        upd_valid = 1'b1; upd_data = 32'h00000000;
        tick();
        wait_t("t6_pos", SD + 4, 40);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_async_disp1", 32'(display1), 32'hFF);
        chk("t6_async_ready", 32'(upd_ready), 32'd1);
        chk("t6_async_ctl", 32'(ssd_ctl), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        saw_stale = 0;
        for (int n = 0; n < 70; n++) begin
            tick();
            for (int i = 0; i < 4; i++) if (disp[i] == 8'h00) saw_stale = 1;
        end
        chk("t6_no_stale_frame", 32'(saw_stale), 32'd0);

`ifdef SSD_SCAN_DIM_EN
        // dimming: bright=4 lights 4 of the 6 SHOW cycles of a slot
        upd_valid = 1'b1; upd_data = 32'h11223344; bright = 4'd4;
        tick();
        bright = 4'hF;
        wait_fd("dim_wait_fd", 40);
        on_cnt = 0;
        for (int p = 0; p < SD; p++) begin
            if (display0 != 8'hFF) on_cnt++;
            tick();
        end
        chk("dim_on_cnt", 32'(on_cnt), 32'd4);
`else
        on_cnt = 0;
`endif

        // randomized traffic and enable drops against the model
        for (int n = 0; n < 2500; n++) begin
            if (!upd_valid && $urandom_range(0, 19) == 0) begin
                upd_valid = 1'b1;
                upd_data  = $urandom;
`ifdef SSD_SCAN_DIM_EN
                bright    = 4'($urandom_range(0, 15));
`endif
            end
            if (en && $urandom_range(0, 299) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
